// File: rtl/temp_sensor_spi_responder.sv
// LM71-style 3-wire SPI responder. It returns a temperature word, or the ID word in
// shutdown, then accepts a 16-bit command. All link inputs are oversampled on clk_50.
module temp_sensor_spi_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DEVICE_ID   = 16'h800F
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        temp_cs_n,
    input  logic        temp_sc,
    input  logic        temp_sio_in,
    output logic        temp_sio_out,
    output logic        temp_sio_oe,
    input  logic [13:0] temp_value,
    output logic [15:0] cmd_word,
    output logic        cmd_valid,
    output logic        shutdown,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for CS_n fall, pad not driven
    // READ  | shifting the tx word out, MSB first, on SC falls
    // WRITE | shifting the command in, MSB first, on SC rises
    // DONE  | command taken, ignoring SC until CS_n rises
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync, sc_sync, sio_sync;
    logic                   cs_h, sc_h, sio_h;
    logic                   cs_rise, cs_fall, sc_rise, sc_fall;
    logic [15:0]            tx_shift, rx_shift, load_word, rx_next;
    logic [3:0]             bit_cnt;

    assign load_word = shutdown ? DEVICE_ID : {temp_value, 2'b11};
    assign rx_next   = {rx_shift[14:0], sio_h};

    // Edge pulses are registered so every edge reaches the FSM at the same latency;
    // sio_h lines up with the sample that produced the SC edge pulse.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync  <= '0;
            sc_sync  <= '0;
            sio_sync <= '0;
            cs_h     <= 1'b0;
            sc_h     <= 1'b0;
            sio_h    <= 1'b0;
            cs_rise  <= 1'b0;
            cs_fall  <= 1'b0;
            sc_rise  <= 1'b0;
            sc_fall  <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], temp_cs_n};
            sc_sync  <= {sc_sync[SYNC_STAGES-2:0], temp_sc};
            sio_sync <= {sio_sync[SYNC_STAGES-2:0], temp_sio_in};
            cs_h     <= cs_sync[SYNC_STAGES-1];
            sc_h     <= sc_sync[SYNC_STAGES-1];
            sio_h    <= sio_sync[SYNC_STAGES-1];
            cs_rise  <= ~cs_h & cs_sync[SYNC_STAGES-1];
            cs_fall  <= cs_h & ~cs_sync[SYNC_STAGES-1];
            sc_rise  <= ~sc_h & sc_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES-1];
            sc_fall  <= sc_h & ~sc_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            tx_shift     <= '0;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            temp_sio_out <= 1'b0;
            temp_sio_oe  <= 1'b0;
            cmd_word     <= '0;
            cmd_valid    <= 1'b0;
            shutdown     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (cs_rise) begin
                state        <= IDLE;
                temp_sio_oe  <= 1'b0;
                temp_sio_out <= 1'b0;
                bit_cnt      <= '0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            tx_shift     <= load_word;
                            temp_sio_out <= load_word[15];
                            temp_sio_oe  <= 1'b1;
                            bit_cnt      <= '0;
                            busy         <= 1'b1;
                            state        <= READ;
                        end
                    end
                    READ: begin
                        if (sc_fall) begin
                            tx_shift <= {tx_shift[14:0], 1'b0};
                            if (bit_cnt == 4'd15) begin
                                bit_cnt      <= '0;
                                temp_sio_oe  <= 1'b0;
                                temp_sio_out <= 1'b0;
                                state        <= WRITE;
                            end else begin
                                bit_cnt      <= bit_cnt + 4'd1;
                                temp_sio_out <= tx_shift[14];
                            end
                        end
                    end
                    WRITE: begin
                        if (sc_rise) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                cmd_word  <= rx_next;
                                cmd_valid <= 1'b1;
                                if (rx_next == 16'hFFFF)
                                    shutdown <= 1'b1;
                                else if (rx_next == 16'h0000)
                                    shutdown <= 1'b0;
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        temp_sio_oe <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_temp_sensor_spi_responder.sv
// Randomized bench for temp_sensor_spi_responder: an initiator task plays the link,
// a reference model predicts read words and commands, a monitor checks them.
module tb_temp_sensor_spi_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        sc = 1'b0;
    logic        sio_drv = 1'b0;
    logic [13:0] temp_value = '0;
    logic        temp_sio_out, temp_sio_oe, cmd_valid, shutdown, busy;
    logic [15:0] cmd_word;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] exp_read_q[$];
    logic [15:0] act_read_q[$];
    logic [16:0] exp_cmd_q[$];
    logic        ref_sd = 1'b0;
    logic [15:0] ref_cmd = 16'h0000;

    temp_sensor_spi_responder #(.SYNC_STAGES(2), .DEVICE_ID(16'h800F)) dut (
        .clk_50(clk), .reset_n(reset_n), .temp_cs_n(cs_n), .temp_sc(sc),
        .temp_sio_in(sio_drv), .temp_sio_out(temp_sio_out), .temp_sio_oe(temp_sio_oe),
        .temp_value(temp_value), .cmd_word(cmd_word), .cmd_valid(cmd_valid),
        .shutdown(shutdown), .busy(busy)
    );

    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compares whatever the DUT presents against the model's queues.
    always @(negedge clk) begin
        if (reset_n && cmd_valid) begin
            if (exp_cmd_q.size() == 0) begin
                check("unexpected_cmd_valid", {31'd0, cmd_valid}, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_cmd_q.pop_front();
                check("cmd_word", {16'd0, cmd_word}, {16'd0, e[16:1]});
                check("shutdown_at_cmd", {31'd0, shutdown}, {31'd0, e[0]});
            end
        end
        if (act_read_q.size() > 0 && exp_read_q.size() > 0)
            check("read_word", {16'd0, act_read_q.pop_front()}, {16'd0, exp_read_q.pop_front()});
    end

    // One link transaction; rd_bits/wr_bits below 16 abort with an early CS_n rise.
    task automatic xact(input logic [13:0] temp, input logic [15:0] cmd, input int rd_bits,
                        input int wr_bits, input logic change_temp, output logic [15:0] got);
        logic [15:0] exp_rd;
        got = '0;
        temp_value = temp;
        exp_rd = ref_sd ? 16'h800F : {temp, 2'b11};
        cs_n = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < rd_bits; i++) begin
            sc = 1'b1;
            got = {got[14:0], temp_sio_out};
            check("read_oe", {31'd0, temp_sio_oe}, 32'd1);
            wait_cyc(8);
            sc = 1'b0;
            if (change_temp && i == 5) temp_value = 14'h0000;
            wait_cyc(8);
        end
        if (rd_bits < 16) begin
            cs_n = 1'b1;
            wait_cyc(6);
            check("abort_oe", {31'd0, temp_sio_oe}, 32'd0);
            check("abort_busy", {31'd0, busy}, 32'd0);
            wait_cyc(4);
        end else begin
            exp_read_q.push_back(exp_rd);
            act_read_q.push_back(got);
            if (wr_bits == 16) begin
                ref_cmd = cmd;
                if (cmd == 16'hFFFF) ref_sd = 1'b1;
                else if (cmd == 16'h0000) ref_sd = 1'b0;
                exp_cmd_q.push_back({cmd, ref_sd});
            end
            for (int j = 0; j < wr_bits; j++) begin
                sio_drv = cmd[15-j];
                wait_cyc(8);
                if (j == 0) check("write_oe", {31'd0, temp_sio_oe}, 32'd0);
                sc = 1'b1;
                wait_cyc(8);
                sc = 1'b0;
            end
            wait_cyc(8);
            cs_n = 1'b1;
            wait_cyc(8);
        end
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_shutdown", {31'd0, shutdown}, {31'd0, ref_sd});
        check("end_cmd_word", {16'd0, cmd_word}, {16'd0, ref_cmd});
    endtask

    initial begin
        logic [15:0] rd;
        logic [13:0] t;
        logic [15:0] c;

        #25;
        check("rst_sio_out", {31'd0, temp_sio_out}, 32'd0);
        check("rst_oe", {31'd0, temp_sio_oe}, 32'd0);
        check("rst_cmd_word", {16'd0, cmd_word}, 32'd0);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_shutdown", {31'd0, shutdown}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(10);

        xact(14'h0320, 16'h1234, 16, 16, 1'b0, rd);
        check("read_25c", {16'd0, rd}, 32'h0C83);
        xact(14'h3CE0, 16'h5A5A, 16, 16, 1'b1, rd);
        check("read_m25c", {16'd0, rd}, 32'hF383);

        xact(14'(($urandom)), 16'hFFFF, 16, 16, 1'b0, rd);
        xact(14'(($urandom)), 16'h1111, 16, 16, 1'b0, rd);
        check("read_id", {16'd0, rd}, 32'h800F);
        xact(14'(($urandom)), 16'h0000, 16, 16, 1'b0, rd);
        t = 14'($urandom);
        xact(t, 16'h2222, 16, 16, 1'b0, rd);
        check("read_after_exit", {16'd0, rd}, {16'd0, t, 2'b11});

        xact(14'h0123, 16'h0000, 7, 0, 1'b0, rd);
        xact(14'h0456, 16'h3333, 16, 16, 1'b0, rd);
        check("read_after_abort", {16'd0, rd}, {16'd0, 14'h0456, 2'b11});

        xact(14'h0789, 16'hFFFF, 16, 10, 1'b0, rd);

        // Asynchronous reset mid-read after entering shutdown.
        xact(14'(($urandom)), 16'hFFFF, 16, 16, 1'b0, rd);
        cs_n = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 3; i++) begin
            sc = 1'b1;
            wait_cyc(8);
            sc = 1'b0;
            wait_cyc(8);
        end
        check("pre_reset_oe", {31'd0, temp_sio_oe}, 32'd1);
        #5;
        reset_n = 1'b0;
        ref_sd = 1'b0;
        ref_cmd = 16'h0000;
        #1;
        check("areset_oe", {31'd0, temp_sio_oe}, 32'd0);
        check("areset_sio_out", {31'd0, temp_sio_out}, 32'd0);
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_shutdown", {31'd0, shutdown}, 32'd0);
        check("areset_cmd_word", {16'd0, cmd_word}, 32'd0);
        check("areset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        cs_n = 1'b1;
        wait_cyc(4);
        reset_n = 1'b1;
        wait_cyc(10);
        xact(14'h1ABC, 16'hA5A5, 16, 16, 1'b0, rd);
        check("read_after_reset", {16'd0, rd}, {16'd0, 14'h1ABC, 2'b11});

        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0: c = 16'hFFFF;
                1: c = 16'h0000;
                default: c = 16'($urandom);
            endcase
            if ($urandom_range(0, 5) == 0)
                xact(14'($urandom), c, 16, $urandom_range(1, 15), 1'b0, rd);
            else
                xact(14'($urandom), c, 16, 16, 1'b0, rd);
        end

        wait_cyc(20);
        check("cmd_queue_drained", exp_cmd_q.size(), 32'd0);
        check("read_queue_drained", exp_read_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
